// File: rtl/sd_interp.sv
// Linear interpolator feeding the sigma-delta modulator: one new BW-bit point per clock.
// Latency: accepted sample -> segment load next edge -> endpoint reached R edges later.
// Backpressure: 1-entry pending buffer, ready = !pend_v (registered); one sample per R clocks max.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   sample_i        signed PCM input sample (BW bits)
//   sample_valid_i  sample_i is valid
//   sample_ready_o  pending buffer empty, a sample can be taken this cycle
//   dac_o           signed interpolated value for the modulator's dac_i
//   underrun_o      one-cycle pulse when a segment ends with nothing pending
//   busy_o          high while a segment is being ramped
module sd_interp #(
  parameter int BW       = 8,
  parameter int OSR_LOG2 = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [BW-1:0] sample_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  output logic [BW-1:0] dac_o,
  output logic          underrun_o,
  output logic          busy_o
);

  // Slope spans two full-range endpoints, so it needs one bit more than a
  // sample. The accumulator holds value * R plus a sign-headroom bit.
  localparam int SW = BW + 1;
  localparam int AW = BW + OSR_LOG2 + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  // End point of the current segment; after a segment finishes it is also
  // the value dac_o holds and the start point of the next segment.
  logic [BW-1:0]         endp_q, endp_d;
  logic signed [SW-1:0]  slope_q, slope_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [OSR_LOG2-1:0]   phase_q, phase_d;
  logic [BW-1:0]         dac_q, dac_d;
  logic                  underrun_q, underrun_d;

  logic signed [SW-1:0]  slope_load;
  logic signed [AW-1:0]  acc_load;
  logic signed [AW-1:0]  acc_step;
  logic                  seg_end;
  logic                  take;

  // Values for starting a segment from the current endpoint toward pend.
  assign slope_load = $signed({pend_q[BW-1], pend_q}) - $signed({endp_q[BW-1], endp_q});
  assign acc_load   = $signed({endp_q[BW-1], endp_q, {OSR_LOG2{1'b0}}});
  assign acc_step   = acc_q + $signed({{OSR_LOG2{slope_q[SW-1]}}, slope_q});

  // Phase counts edges already taken in this segment; the edge taken while
  // it reads all-ones is the R-th, which lands exactly on the endpoint.
  assign seg_end = (phase_q == {OSR_LOG2{1'b1}});

  // A load always needs pend_v set, so it can never coincide with a take.
  assign take = sample_valid_i && !pend_v_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    endp_d     = endp_q;
    slope_d    = slope_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    dac_d      = dac_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        // dac_o keeps the held endpoint on the load edge.
        if (pend_v_q) begin
          endp_d   = pend_q;
          slope_d  = slope_load;
          acc_d    = acc_load;
          phase_d  = '0;
          pend_v_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_step;
        phase_d = phase_q + 1'b1;
        // Arithmetic shift by OSR_LOG2 with truncation = floor(acc / R).
        dac_d   = acc_step[OSR_LOG2 +: BW];
        if (seg_end) begin
          if (pend_v_q) begin
            // Back-to-back segment: acc_load equals acc_step here since the
            // ramp ends exactly on endp_q, so the ramp continues seamlessly.
            endp_d   = pend_q;
            slope_d  = slope_load;
            acc_d    = acc_load;
            phase_d  = '0;
            pend_v_d = 1'b0;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      pend_d   = sample_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      endp_q     <= '0;
      slope_q    <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      dac_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      endp_q     <= endp_d;
      slope_q    <= slope_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready_o = !pend_v_q;
  assign dac_o          = dac_q;
  assign underrun_o     = underrun_q;
  assign busy_o         = (state_q == RUN);

endmodule

// File: tb/tb_sd_interp.sv
module tb_sd_interp;

  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [BW-1:0] smp  [2];
  logic          vld  [2];
  logic          rdy  [2];
  logic [BW-1:0] dac  [2];
  logic          und  [2];
  logic          busy [2];

  // Instance 0: R = 4, instance 1: R = 16.
  sd_interp #(.BW(BW), .OSR_LOG2(2)) u_dut_r4 (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(smp[0]), .sample_valid_i(vld[0]),
    .sample_ready_o(rdy[0]), .dac_o(dac[0]), .underrun_o(und[0]), .busy_o(busy[0])
  );
  sd_interp #(.BW(BW), .OSR_LOG2(4)) u_dut_r16 (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(smp[1]), .sample_valid_i(vld[1]),
    .sample_ready_o(rdy[1]), .dac_o(dac[1]), .underrun_o(und[1]), .busy_o(busy[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: segments described by start/end points and step index m;
  // output computed directly as start + floor((end-start)*m/R).
  int m_pv [2];
  int m_p  [2];
  int m_run[2];
  int m_st [2];
  int m_en [2];
  int m_m  [2];
  int m_dac[2];
  int m_und[2];
  bit last_acc [2];

  function automatic int sx(logic [BW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ratio(int i);
    return (i == 0) ? 4 : 16;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = 0; m_p[i] = 0; m_run[i] = 0; m_st[i] = 0;
      m_en[i] = 0; m_m[i] = 0; m_dac[i] = 0; m_und[i] = 0;
    end
  endtask

  task automatic mdl_step(int i);
    bit take;
    int r;
    r = ratio(i);
    take = vld[i] && (m_pv[i] == 0);
    m_und[i] = 0;
    if (m_run[i] == 0) begin
      if (m_pv[i] != 0) begin
        m_st[i] = m_en[i]; m_en[i] = m_p[i]; m_m[i] = 0; m_run[i] = 1; m_pv[i] = 0;
      end
    end else begin
      m_m[i] = m_m[i] + 1;
      m_dac[i] = m_st[i] + fdiv((m_en[i] - m_st[i]) * m_m[i], r);
      if (m_m[i] == r) begin
        if (m_pv[i] != 0) begin
          m_st[i] = m_en[i]; m_en[i] = m_p[i]; m_m[i] = 0; m_pv[i] = 0;
        end else begin
          m_run[i] = 0; m_und[i] = 1;
        end
      end
    end
    if (take) begin
      m_p[i] = sx(smp[i]);
      m_pv[i] = 1;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances with the same inputs the DUT sees, then
  // outputs are compared 1 time unit after the edge.
  task automatic tick();
    for (int i = 0; i < 2; i++) last_acc[i] = vld[i] && rdy[i];
    @(posedge clk);
    mdl_step(0);
    mdl_step(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model dac[%0d]", i), sx(dac[i]), m_dac[i]);
      chk($sformatf("model ready[%0d]", i), int'(rdy[i]), (m_pv[i] == 0) ? 1 : 0);
      chk($sformatf("model underrun[%0d]", i), int'(und[i]), m_und[i]);
      chk($sformatf("model busy[%0d]", i), int'(busy[i]), m_run[i]);
    end
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic apply_reset();
    vld[0] = 1'b0; vld[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dac[%0d]", i), sx(dac[i]), 0);
      chk($sformatf("reset ready[%0d]", i), int'(rdy[i]), 1);
      chk($sformatf("reset busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("reset underrun[%0d]", i), int'(und[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst;
    bit v;
    int s;
    int e_dac;
    bit e_rdy;
    bit e_und;
    bit e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v, int s, int d, bit r, bit u, bit b);
    vec_t x;
    x.rst = rst; x.v = v; x.s = s; x.e_dac = d; x.e_rdy = r; x.e_und = u; x.e_busy = b;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int tmp;
    int nxt;
    int n_acc;
    int n_und;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; smp[i] = '0; last_acc[i] = 1'b0;
    end
    mdl_reset();

    // Ramp 0 -> 64, one segment, then underrun.
    tbl.push_back(mk(1, 1,  64,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 16, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 32, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 48, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 64, 1, 1, 0));
    tbl.push_back(mk(0, 0,   0, 64, 1, 0, 0));
    // Ramp 0 -> -3, floor rounding on negatives.
    tbl.push_back(mk(1, 1,  -3,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, -1, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, -2, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, -3, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, -3, 1, 1, 0));
    tbl.push_back(mk(0, 0,   0, -3, 1, 0, 0));
    // Full-scale swing -128 -> 127 streamed back to back.
    tbl.push_back(mk(1, 1, -128,    0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  127,    0, 1, 0, 1));
    tbl.push_back(mk(0, 1,  127,  -32, 0, 0, 1));
    tbl.push_back(mk(0, 0,    0,  -64, 0, 0, 1));
    tbl.push_back(mk(0, 0,    0,  -96, 0, 0, 1));
    tbl.push_back(mk(0, 0,    0, -128, 1, 0, 1));
    tbl.push_back(mk(0, 0,    0,  -65, 1, 0, 1));
    tbl.push_back(mk(0, 0,    0,   -1, 1, 0, 1));
    tbl.push_back(mk(0, 0,    0,   63, 1, 0, 1));
    tbl.push_back(mk(0, 0,    0,  127, 1, 1, 0));
    tbl.push_back(mk(0, 0,    0,  127, 1, 0, 0));

    foreach (tbl[k]) begin
      if (tbl[k].rst) apply_reset();
      tmp = tbl[k].s;
      vld[0] = tbl[k].v;
      smp[0] = tmp[7:0];
      tick();
      chk($sformatf("vec%0d dac", k), sx(dac[0]), tbl[k].e_dac);
      chk($sformatf("vec%0d ready", k), int'(rdy[0]), int'(tbl[k].e_rdy));
      chk($sformatf("vec%0d underrun", k), int'(und[0]), int'(tbl[k].e_und));
      chk($sformatf("vec%0d busy", k), int'(busy[0]), int'(tbl[k].e_busy));
    end

    // Sample delivered exactly on the segment-end edge.
    apply_reset();
    vld[0] = 1'b1; smp[0] = 8'd40;
    tick();
    vld[0] = 1'b0;
    tick();
    tick(); tick(); tick();
    chk("segend pre dac", sx(dac[0]), 30);
    vld[0] = 1'b1; smp[0] = 8'd80;
    tick();
    vld[0] = 1'b0;
    chk("segend underrun", int'(und[0]), 1);
    chk("segend busy", int'(busy[0]), 0);
    chk("segend ready", int'(rdy[0]), 0);
    chk("segend dac", sx(dac[0]), 40);
    tick();
    chk("segend load busy", int'(busy[0]), 1);
    chk("segend load dac", sx(dac[0]), 40);
    chk("segend load underrun", int'(und[0]), 0);
    tick();
    chk("segend ramp dac", sx(dac[0]), 50);
    repeat (4) tick();
    chk("segend final dac", sx(dac[0]), 80);

    // Reset in the middle of a ramp, then ramp from 0 again.
    apply_reset();
    vld[0] = 1'b1; smp[0] = 8'd100;
    tick();
    vld[0] = 1'b0;
    tick(); tick(); tick();
    chk("midrst pre dac", sx(dac[0]), 50);
    apply_reset();
    vld[0] = 1'b1; smp[0] = 8'd8;
    tick();
    vld[0] = 1'b0;
    tick();
    tick();
    chk("midrst restart dac", sx(dac[0]), 2);
    repeat (4) tick();

    // Continuous stream at R = 16 with valid held high.
    apply_reset();
    nxt = 0;
    smp[1] = '0;
    vld[1] = 1'b1;
    n_acc = 0;
    n_und = 0;
    for (int c = 0; c < 192; c++) begin
      tick();
      if (last_acc[1]) begin
        nxt = nxt + 10;
        smp[1] = nxt[7:0];
        if (c >= 32) n_acc++;
      end
      if (c >= 2 && und[1]) n_und++;
    end
    chk("stream accepts per 160 clocks", n_acc, 10);
    chk("stream underruns", n_und, 0);
    vld[1] = 1'b0;
    repeat (40) tick();

    // Random traffic on both instances against the model.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) apply_reset();
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        tmp = int'($urandom);
        smp[i] = tmp[7:0];
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
